// File: rtl/temporizador_interrupcao.sv
// temporizador_interrupcao
// Preemption timer and interrupt controller for the CPU's PC-select and
// interrupt-cause logic. It counts a software-programmed quantum while user
// code runs and raises a one-cycle clock interrupt when the quantum expires.
// It raises a one-cycle halt interrupt when a user process executes HALT.
// The interrupt cause and the resume PC are latched, and further events are
// masked until the kernel acknowledges.
//
// Optional feature: define TIMER_AUTORELOAD_EN to keep the last accepted
// quantum in quantum_salvo. An acknowledge of a clock interrupt then restarts
// the count automatically. Without the macro, every acknowledge returns to
// PARADO and the kernel must issue SetClock again.
//
// Ports:
//   Clock          in   CPU clock; all state updates on posedge
//   Reset          in   synchronous, active-high; dominates every other input
//   Halt           in   HALT instruction decoded this cycle
//   SetClock       in   load quantum from Tempo
//   Tempo          in   quantum in user-region cycles
//   PC             in   current instruction address
//   PCProximo      in   next-PC value that would have been taken
//   GetInterrupcao in   kernel acknowledge / cause read
//   IntHalt        out  one-cycle halt-interrupt pulse
//   IntClk         out  one-cycle timer-interrupt pulse
//   Causa          out  0 none, 1 clock, 2 halt
//   PCSalvo        out  resume address captured on IntClk
//   TimerAtivo     out  high while the FSM is in CONTANDO
//   estado_dbg     out  current FSM state (0 PARADO, 1 CONTANDO, 2 AGUARDA_ACK)
//
// Handshake: this block has no valid/ready pair. An interrupt is raised once
// as a one-cycle pulse, then Causa holds until GetInterrupcao is seen in
// AGUARDA_ACK. Events arriving in that window are dropped, not queued.

module temporizador_interrupcao #(
  parameter int                    LARGURA_PC    = 11,
  parameter int                    LARGURA_TEMPO = 16,
  parameter logic [LARGURA_PC-1:0] KERNEL_LIMITE = 11'd64
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Halt,
  input  logic                     SetClock,
  input  logic [LARGURA_TEMPO-1:0] Tempo,
  input  logic [LARGURA_PC-1:0]    PC,
  input  logic [LARGURA_PC-1:0]    PCProximo,
  input  logic                     GetInterrupcao,
  output logic                     IntHalt,
  output logic                     IntClk,
  output logic [31:0]              Causa,
  output logic [LARGURA_PC-1:0]    PCSalvo,
  output logic                     TimerAtivo,
  output logic [1:0]               estado_dbg
);

  typedef enum logic [1:0] {
    PARADO      = 2'd0,
    CONTANDO    = 2'd1,
    AGUARDA_ACK = 2'd2
  } estado_t;

  localparam logic [31:0] CAUSA_NENHUMA = 32'd0;
  localparam logic [31:0] CAUSA_CLOCK   = 32'd1;
  localparam logic [31:0] CAUSA_HALT    = 32'd2;

  estado_t                  estado_q, estado_d;
  logic [LARGURA_TEMPO-1:0] cnt_q, cnt_d;
  logic [31:0]              causa_q, causa_d;
  logic [LARGURA_PC-1:0]    pc_salvo_q, pc_salvo_d;
  logic                     int_halt_q, int_halt_d;
  logic                     int_clk_q, int_clk_d;
  logic                     timer_ativo_q, timer_ativo_d;
  logic                     regiao_usuario;
`ifdef TIMER_AUTORELOAD_EN
  logic [LARGURA_TEMPO-1:0] quantum_salvo_q, quantum_salvo_d;
`endif

  always_comb begin
    estado_d       = estado_q;
    cnt_d          = cnt_q;
    causa_d        = causa_q;
    pc_salvo_d     = pc_salvo_q;
    int_halt_d     = 1'b0;
    int_clk_d      = 1'b0;
    regiao_usuario = (PC >= KERNEL_LIMITE);
`ifdef TIMER_AUTORELOAD_EN
    quantum_salvo_d = quantum_salvo_q;
`endif

    case (estado_q)
      PARADO, CONTANDO: begin
        // Priority: user-region Halt, then SetClock, then expiry.
        if (Halt && regiao_usuario) begin
          int_halt_d = 1'b1;
          causa_d    = CAUSA_HALT;
          cnt_d      = '0;
          estado_d   = AGUARDA_ACK;
        end else if (SetClock) begin
          if (Tempo != '0) begin
            cnt_d    = Tempo;
            estado_d = CONTANDO;
`ifdef TIMER_AUTORELOAD_EN
            quantum_salvo_d = Tempo;
`endif
          end else begin
            // A zero quantum stops the timer instead of arming it.
            cnt_d    = '0;
            estado_d = PARADO;
          end
        end else if ((estado_q == CONTANDO) && regiao_usuario && (cnt_q != '0)) begin
          // Kernel cycles freeze the count; the counter saturates at zero.
          cnt_d = cnt_q - LARGURA_TEMPO'(1);
          if (cnt_q == LARGURA_TEMPO'(1)) begin
            int_clk_d  = 1'b1;
            causa_d    = CAUSA_CLOCK;
            pc_salvo_d = PCProximo;
            estado_d   = AGUARDA_ACK;
          end
        end
      end

      AGUARDA_ACK: begin
        if (GetInterrupcao) begin
          causa_d  = CAUSA_NENHUMA;
          cnt_d    = '0;
          estado_d = PARADO;
`ifdef TIMER_AUTORELOAD_EN
          if (causa_q == CAUSA_CLOCK) begin
            cnt_d    = quantum_salvo_q;
            estado_d = CONTANDO;
          end
`endif
        end
      end

      default: begin
        estado_d = PARADO;
        cnt_d    = '0;
      end
    endcase

    timer_ativo_d = (estado_d == CONTANDO);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q      <= PARADO;
      cnt_q         <= '0;
      causa_q       <= CAUSA_NENHUMA;
      pc_salvo_q    <= '0;
      int_halt_q    <= 1'b0;
      int_clk_q     <= 1'b0;
      timer_ativo_q <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      quantum_salvo_q <= '0;
`endif
    end else begin
      estado_q      <= estado_d;
      cnt_q         <= cnt_d;
      causa_q       <= causa_d;
      pc_salvo_q    <= pc_salvo_d;
      int_halt_q    <= int_halt_d;
      int_clk_q     <= int_clk_d;
      timer_ativo_q <= timer_ativo_d;
`ifdef TIMER_AUTORELOAD_EN
      quantum_salvo_q <= quantum_salvo_d;
`endif
    end
  end

  assign IntHalt    = int_halt_q;
  assign IntClk     = int_clk_q;
  assign Causa      = causa_q;
  assign PCSalvo    = pc_salvo_q;
  assign TimerAtivo = timer_ativo_q;
  assign estado_dbg = estado_q;

endmodule

// File: tb/tb_temporizador_interrupcao.sv
// Directed testbench for temporizador_interrupcao. Each step pushes the
// expected output word to a queue, clocks the DUT once, then pops and
// compares against the sampled outputs 1 ns after the rising edge.
module tb_temporizador_interrupcao;

  localparam int LPC = 11;
  localparam int LT  = 16;
  localparam int W   = 1 + 1 + 32 + LPC + 1;

  logic            Clock;
  logic            Reset;
  logic            Halt;
  logic            SetClock;
  logic [LT-1:0]   Tempo;
  logic [LPC-1:0]  PC;
  logic [LPC-1:0]  PCProximo;
  logic            GetInterrupcao;
  logic            IntHalt;
  logic            IntClk;
  logic [31:0]     Causa;
  logic [LPC-1:0]  PCSalvo;
  logic            TimerAtivo;
  logic [1:0]      estado_dbg;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp;
  int           n_fail;

  temporizador_interrupcao #(
    .LARGURA_PC   (LPC),
    .LARGURA_TEMPO(LT),
    .KERNEL_LIMITE(11'd64)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Halt          (Halt),
    .SetClock      (SetClock),
    .Tempo         (Tempo),
    .PC            (PC),
    .PCProximo     (PCProximo),
    .GetInterrupcao(GetInterrupcao),
    .IntHalt       (IntHalt),
    .IntClk        (IntClk),
    .Causa         (Causa),
    .PCSalvo       (PCSalvo),
    .TimerAtivo    (TimerAtivo),
    .estado_dbg    (estado_dbg)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Driver tasks
  task automatic drive(input logic rst, input logic hlt, input logic setc,
                       input int tmp, input int pc_v, input int pcp_v,
                       input logic ack);
    Reset          = rst;
    Halt           = hlt;
    SetClock       = setc;
    Tempo          = LT'(tmp);
    PC             = LPC'(pc_v);
    PCProximo      = LPC'(pcp_v);
    GetInterrupcao = ack;
  endtask

  // Push the expectation for the next edge, clock, then pop and compare.
  task automatic step(input string tag, input logic ih, input logic ic,
                      input int causa, input int pcs, input logic ta);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    string        t;
    exp_q.push_back({ih, ic, 32'(causa), LPC'(pcs), ta});
    tag_q.push_back(tag);
    @(posedge Clock);
    #1;
    obs_v = {IntHalt, IntClk, Causa, PCSalvo, TimerAtivo};
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed ih=%0b ic=%0b causa=%0d pcs=%0d ta=%0b expected ih=%0b ic=%0b causa=%0d pcs=%0d ta=%0b",
             t, obs_v[W-1], obs_v[W-2], obs_v[W-3 -: 32], obs_v[LPC:1], obs_v[0],
             exp_v[W-1], exp_v[W-2], exp_v[W-3 -: 32], exp_v[LPC:1], exp_v[0]);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    drive(1, 0, 0, 0, 0, 0, 0);

    // Reset state
    step("reset", 0, 0, 0, 0, 0);

    // Quantum of 3 at a constant user PC
    drive(0, 0, 1, 3, 100, 101, 0);
    step("t3_load", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 101, 0);
    step("t3_c1", 0, 0, 0, 0, 1);
    step("t3_c2", 0, 0, 0, 0, 1);
    step("t3_expiry", 0, 1, 1, 101, 0);
    step("t3_pulse_end", 0, 0, 1, 101, 0);

    // Waiting for ack: Halt and SetClock are both masked
    drive(0, 1, 1, 7, 100, 150, 0);
    step("ack_mask", 0, 0, 1, 101, 0);
    drive(0, 0, 0, 0, 100, 150, 1);
`ifdef TIMER_AUTORELOAD_EN
    step("ack_clear", 0, 0, 0, 101, 1);
    drive(0, 0, 0, 0, 100, 160, 0);
    step("reload_c1", 0, 0, 0, 101, 1);
    step("reload_c2", 0, 0, 0, 101, 1);
    step("reload_expiry", 0, 1, 1, 160, 0);
`else
    step("ack_clear", 0, 0, 0, 101, 0);
    drive(0, 0, 0, 0, 100, 160, 0);
    step("idle_c1", 0, 0, 0, 101, 0);
    step("idle_c2", 0, 0, 0, 101, 0);
    step("idle_c3", 0, 0, 0, 101, 0);
`endif
    // Reset while SetClock is also high: reset wins
    drive(1, 0, 1, 5, 100, 0, 0);
    step("reset_dom", 0, 0, 0, 0, 0);

    // Quantum of 5 with PC alternating kernel/user: 10 cycles to expire
    drive(0, 0, 1, 5, 10, 200, 0);
    step("alt_load", 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, (i % 2 == 0) ? 10 : 100, 200, 0);
      if (i < 9) step("alt_count", 0, 0, 0, 0, 1);
      else       step("alt_expiry", 0, 1, 1, 200, 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    step("alt_reset", 0, 0, 0, 0, 0);

    // Halt at a user PC while cnt=1 overrides the expiry
    drive(0, 0, 1, 2, 100, 300, 0);
    step("h_load", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 300, 0);
    step("h_cnt1", 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 100, 300, 0);
    step("h_pulse", 1, 0, 2, 0, 0);
    drive(0, 0, 0, 0, 100, 300, 0);
    step("h_pulse_end", 0, 0, 2, 0, 0);
    step("h_no_clk", 0, 0, 2, 0, 0);
    drive(0, 0, 0, 0, 100, 300, 1);
    step("h_ack", 0, 0, 0, 0, 0);

    // Halt in the kernel region is ignored, idle and while counting
    drive(0, 1, 0, 0, 10, 300, 0);
    step("kh_idle", 0, 0, 0, 0, 0);
    drive(0, 0, 1, 2, 10, 310, 0);
    step("kh_load", 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 10, 310, 0);
    step("kh_count", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 310, 0);
    step("kh_c1", 0, 0, 0, 0, 1);
    step("kh_expiry", 0, 1, 1, 310, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step("kh_reset", 0, 0, 0, 0, 0);

    // SetClock 9 on the expiry edge of a quantum of 2
    drive(0, 0, 1, 2, 100, 400, 0);
    step("sc_load2", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 400, 0);
    step("sc_cnt1", 0, 0, 0, 0, 1);
    drive(0, 0, 1, 9, 100, 400, 0);
    step("sc_reload9", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 410, 0);
    for (int i = 1; i <= 9; i++) begin
      if (i < 9) step("sc_count", 0, 0, 0, 0, 1);
      else       step("sc_expiry9", 0, 1, 1, 410, 0);
    end

    // Reset mid-count (cnt=4), then no pulse afterward
    drive(1, 0, 0, 0, 0, 0, 0);
    step("rc_pre", 0, 0, 0, 0, 0);
    drive(0, 0, 1, 6, 100, 500, 0);
    step("rc_load", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 500, 0);
    step("rc_c5", 0, 0, 0, 0, 1);
    step("rc_c4", 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 100, 500, 0);
    step("rc_reset", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 100, 500, 0);
    for (int i = 0; i < 8; i++) step("rc_quiet", 0, 0, 0, 0, 0);

    // Reset during AGUARDA_ACK discards cause and saved PC
    drive(0, 0, 1, 1, 100, 600, 0);
    step("ra_load", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 100, 600, 0);
    step("ra_expiry", 0, 1, 1, 600, 0);
    drive(1, 0, 0, 0, 100, 600, 0);
    step("ra_reset", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 100, 600, 1);
    for (int i = 0; i < 4; i++) step("ra_quiet", 0, 0, 0, 0, 0);

    // Tempo=0 keeps the timer stopped
    drive(0, 0, 1, 0, 100, 700, 0);
    step("t0_load", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 100, 700, 0);
    step("t0_quiet", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/temporizador_interrupcao.md
# temporizador_interrupcao

Preemption timer and interrupt controller feeding the CPU's PC-select and interrupt-cause logic. Counts a software-programmed quantum while user code runs, raises a one-cycle clock interrupt on expiry, and raises a halt interrupt when a user process executes HALT. It latches the interrupt cause and the resume PC, and masks further events until the kernel acknowledges.

## Interface
Parameters:
- LARGURA_PC, 11, PC/address width
- LARGURA_TEMPO, 16, quantum counter width
- KERNEL_LIMITE, 11'd64, first user-region address; PC < KERNEL_LIMITE is kernel code

Ports:
- Clock  in  1  CPU clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- Halt  in  1  HALT instruction decoded this cycle
- SetClock  in  1  load quantum from Tempo
- Tempo  in  LARGURA_TEMPO  quantum in user-region cycles (instruction immediate)
- PC  in  LARGURA_PC  current instruction address
- PCProximo  in  LARGURA_PC  next-PC value that would have been taken
- GetInterrupcao  in  1  kernel acknowledge / cause read
- IntHalt  out  1  one-cycle halt-interrupt pulse
- IntClk  out  1  one-cycle timer-interrupt pulse
- Causa  out  32  0 none, 1 clock, 2 halt
- PCSalvo  out  LARGURA_PC  resume address captured on IntClk
- TimerAtivo  out  1  high in CONTANDO

## Operation
- States: PARADO, CONTANDO, AGUARDA_ACK.
- PARADO: counter idle. SetClock with Tempo≠0 → cnt=Tempo, CONTANDO. SetClock with Tempo=0 → remain PARADO.
- CONTANDO: cnt decrements by 1 only on cycles with PC ≥ KERNEL_LIMITE; kernel cycles freeze it. A decrement reaching 0 → IntClk=1, Causa=1, PCSalvo=PCProximo, AGUARDA_ACK.
- Halt with PC ≥ KERNEL_LIMITE, in PARADO or CONTANDO → IntHalt=1, Causa=2, cnt=0, AGUARDA_ACK. Halt in the kernel region is ignored by this block.
- AGUARDA_ACK: all new Halt/expiry events are masked, not queued. Causa and PCSalvo hold. GetInterrupcao → Causa=0, exit per Configuration.
- GetInterrupcao outside AGUARDA_ACK: no effect.
- Priorities within one cycle, highest first:
  - Halt (user region): overrides an expiry on the same edge. IntHalt only; PCSalvo unchanged.
  - SetClock: overrides an expiry on the same edge. Reload, no interrupt.
  - Expiry.
- SetClock while CONTANDO reloads cnt. SetClock in AGUARDA_ACK is ignored.
- Counter is unsigned LARGURA_TEMPO bits. It never wraps: it stops at 0.

## Timing
- All outputs registered. Reset values: IntHalt=0, IntClk=0, Causa=0, PCSalvo=0, TimerAtivo=0, cnt=0, state PARADO.
- Reset dominates every other input on the same edge. Reset mid-count or mid-wait discards pending cause and saved PC.
- IntClk rises on the edge of the N-th user-region cycle after the SetClock edge (Tempo=N). Minimum latency is 1 cycle (N=1).
- IntHalt rises on the edge after the user-region Halt cycle.
- Both pulses last exactly one cycle. Never both high together.
- Causa becomes 0 on the edge following GetInterrupcao.

## Configuration
- TIMER_AUTORELOAD_EN defined:
  - Register quantum_salvo captures Tempo on every accepted SetClock.
  - Acknowledge of Causa=1 → cnt=quantum_salvo, CONTANDO.
  - Acknowledge of Causa=2 → PARADO.
- TIMER_AUTORELOAD_EN undefined: quantum_salvo is absent. Every acknowledge → PARADO; the kernel must issue SetClock again.

## Test plan
- Reset, SetClock Tempo=3, PC=100 constant, PCProximo=101 → IntClk high only in 3rd cycle after load; Causa=1, PCSalvo=101, TimerAtivo=0.
- Tempo=5 with PC alternating 100/10 each cycle → expiry after 10 cycles (kernel cycles frozen).
- Halt at PC=100 while cnt=1 → IntHalt pulse, IntClk never, Causa=2. Halt at PC=10 → no pulse.
- In AGUARDA_ACK (Causa=1): Halt at PC=100 and SetClock Tempo=7 → Causa stays 1, no pulses. GetInterrupcao → Causa=0. With TIMER_AUTORELOAD_EN: IntClk again 3 user cycles later. Without: TimerAtivo=0, no further pulse.
- SetClock Tempo=9 on the expiry edge of Tempo=2 → no IntClk; next IntClk 9 user cycles later.
- Reset asserted with cnt=4 and separately during AGUARDA_ACK → all outputs 0 next edge, no pulse afterward.
